// File: rtl/kalman_pkg.sv
// Shared types and constants for the attitude output unit.
// Angle select encoding, frame tags and FSM state types.
package kalman_pkg;

    typedef enum logic [1:0] {
        SEL_ROLL,
        SEL_PITCH,
        SEL_YAW,
        SEL_NONE
    } angle_sel_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } frame_state_t;

    typedef enum logic [1:0] {
        BIT_IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } bit_state_t;

    localparam logic [7:0] TAG_ROLL  = 8'h52;
    localparam logic [7:0] TAG_PITCH = 8'h50;
    localparam logic [7:0] TAG_YAW   = 8'h59;
    localparam int FRAME_BYTES = 3;
    localparam int ANGLE_W     = 16;

    function automatic logic [7:0] sel_tag(angle_sel_t s);
        logic [7:0] t;
        unique case (s)
            SEL_ROLL:  t = TAG_ROLL;
            SEL_PITCH: t = TAG_PITCH;
            SEL_YAW:   t = TAG_YAW;
            SEL_NONE:  t = 8'h00;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/angle_uart_tx_if.sv
// Controller <-> output unit bundle: request, angle words,
// completion pulse, busy flag and the UART line.
interface angle_uart_tx_if;
    import kalman_pkg::*;

    logic               write_enable;
    logic [1:0]         output_sel;
    logic [ANGLE_W-1:0] roll_angle;
    logic [ANGLE_W-1:0] pitch_angle;
    logic [ANGLE_W-1:0] yaw_angle;
    logic               output_done;
    logic               busy;
    logic               tx_out;

    modport master (
        output write_enable, output_sel,
        output roll_angle, pitch_angle, yaw_angle,
        input  output_done, busy, tx_out
    );

    modport slave (
        input  write_enable, output_sel,
        input  roll_angle, pitch_angle, yaw_angle,
        output output_done, busy, tx_out
    );

endinterface

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serializer with its own baud counter.
// A load during the last stop cycle chains bytes with no idle gap.
module uart_byte_tx
    import kalman_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       byte_done
);

    localparam int CNT_W =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    bit_state_t       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             tick;

    assign tick      = (baud_cnt == LAST);
    assign byte_done = (state == STOP_BIT) && tick;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= BIT_IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else if (load) begin
            state    <= START_BIT;
            tx       <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= byte_in;
        end else begin
            if (state == BIT_IDLE || tick)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;
            unique case (state)
                BIT_IDLE: tx <= 1'b1;
                START_BIT: if (tick) begin
                    state <= DATA_BITS;
                    tx    <= shreg[0];
                    shreg <= shreg >> 1;
                end
                DATA_BITS: if (tick) begin
                    if (bit_idx == 3'd7) begin
                        state <= STOP_BIT;
                        tx    <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
                STOP_BIT: if (tick) begin
                    state <= BIT_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/angle_uart_tx.sv
// Attitude output unit: latches one angle and sends tag/LSB/MSB
// as a 3-byte UART frame, then pulses output_done.
module angle_uart_tx
    import kalman_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic            clk,
    input  logic            n_rst,
    angle_uart_tx_if.slave  bus
);

    frame_state_t          state;
    logic [DATA_WIDTH-1:0] word_q;
    logic [1:0]            byte_idx;
    logic                  done_q;
    logic                  busy_q;
    angle_sel_t            sel;
    logic [DATA_WIDTH-1:0] angle_mux;
    logic                  load;
    logic [7:0]            byte_in;
    logic                  byte_done;
    logic                  last_byte;
    logic                  tx;

    assign sel       = angle_sel_t'(bus.output_sel);
    assign last_byte = (byte_idx == 2'(FRAME_BYTES - 1));

    always_comb begin
        angle_mux = '0;
        unique case (sel)
            SEL_ROLL:  angle_mux = bus.roll_angle;
            SEL_PITCH: angle_mux = bus.pitch_angle;
            SEL_YAW:   angle_mux = bus.yaw_angle;
            SEL_NONE:  angle_mux = '0;
        endcase
    end

    // The next byte is handed over on the final stop cycle so the
    // serializer restarts without a gap.
    always_comb begin
        load    = 1'b0;
        byte_in = sel_tag(sel);
        if (state == LOAD) begin
            load = (sel != SEL_NONE);
        end else if (state == SEND && byte_done && !last_byte) begin
            load    = 1'b1;
            byte_in = (byte_idx == 2'd0) ? word_q[7:0]
                                         : word_q[DATA_WIDTH-1 -: 8];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            word_q   <= '0;
            byte_idx <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: if (bus.write_enable) begin
                    state  <= LOAD;
                    busy_q <= 1'b1;
                end
                LOAD: begin
                    word_q   <= angle_mux;
                    byte_idx <= '0;
                    if (sel == SEL_NONE) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        state <= SEND;
                    end
                end
                SEND: if (byte_done) begin
                    if (last_byte) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (load),
        .byte_in  (byte_in),
        .tx       (tx),
        .byte_done(byte_done)
    );

    assign bus.output_done = done_q;
    assign bus.busy        = busy_q;
    assign bus.tx_out      = tx;

endmodule

// File: tb/tb_angle_uart_tx.sv
// Bench for angle_uart_tx: cycle model from frame arithmetic,
// a line receiver, directed scenarios and randomized frames.
module tb_angle_uart_tx;

    localparam int C     = 4;
    localparam int FRAME = 30 * C;

    logic clk   = 1'b0;
    logic n_rst = 1'b1;
    always #5 clk = ~clk;

    angle_uart_tx_if bus();

    angle_uart_tx #(
        .DATA_WIDTH  (16),
        .CLKS_PER_BIT(C)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] tag_of(input logic [1:0] s);
        case (s)
            2'd0:    return 8'h52;
            2'd1:    return 8'h50;
            2'd2:    return 8'h59;
            default: return 8'h00;
        endcase
    endfunction

    // Model: t = cycles since the LOAD cycle, -1 when idle.
    int         t = -1;
    int         t_end = 0;
    bit         m_inv = 1'b0;
    logic [7:0] m_bytes [3];
    logic [15:0] m_a;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            t = -1;
        end else if (t < 0) begin
            if (bus.write_enable) t = 0;
        end else if (t == 0) begin
            m_inv = (bus.output_sel == 2'd3);
            case (bus.output_sel)
                2'd0:    m_a = bus.roll_angle;
                2'd1:    m_a = bus.pitch_angle;
                default: m_a = bus.yaw_angle;
            endcase
            m_bytes[0] = tag_of(bus.output_sel);
            m_bytes[1] = m_a[7:0];
            m_bytes[2] = m_a[15:8];
            t_end = m_inv ? 1 : 1 + FRAME;
            t = 1;
        end else if (t == t_end) begin
            t = -1;
        end else begin
            t++;
        end
    end

    function automatic int exp_line();
        int k;
        int pos;
        if (t < 1 || m_inv || t > FRAME) return 1;
        k   = (t - 1) / C;
        pos = k % 10;
        if (pos == 0) return 0;
        if (pos == 9) return 1;
        return int'(m_bytes[k / 10][pos - 1]);
    endfunction

    always @(negedge clk) begin
        chk("tx_out", int'(bus.tx_out), exp_line());
        chk("busy", int'(bus.busy), int'(t >= 0));
        chk("output_done", int'(bus.output_done),
            int'(t > 0 && t == t_end));
    end

    // Line receiver: samples each bit C cycles after start detect.
    logic [7:0] rxq [$];
    logic [7:0] rx_b;
    initial forever begin
        @(negedge clk);
        if (n_rst && bus.tx_out == 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                repeat (C) @(negedge clk);
                rx_b[i] = bus.tx_out;
            end
            repeat (C) @(negedge clk);
            rxq.push_back(rx_b);
        end
    end

    int done_cnt = 0;
    always @(negedge clk) if (bus.output_done) done_cnt++;

    task automatic chk_rx(input string name, input int base,
                          input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2);
        chk({name, "_b0"}, int'(rxq[base]),     int'(b0));
        chk({name, "_b1"}, int'(rxq[base + 1]), int'(b1));
        chk({name, "_b2"}, int'(rxq[base + 2]), int'(b2));
    endtask

    task automatic request(input logic [1:0] s);
        bus.output_sel   = s;
        bus.write_enable = 1'b1;
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy) return;
        end
    endtask

    task automatic wait_done(input int max, output int lat);
        lat = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (bus.output_done) begin
                lat = i;
                return;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int lat;
    int d0;
    logic [1:0]  s;
    logic [15:0] a;

    initial begin
        bus.write_enable = 1'b0;
        bus.output_sel   = 2'd0;
        bus.roll_angle   = '0;
        bus.pitch_angle  = '0;
        bus.yaw_angle    = '0;
        #1 n_rst = 1'b0;
        @(negedge clk);
        chk("reset_tx", int'(bus.tx_out), 1);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.output_done), 0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("idle_tx", int'(bus.tx_out), 1);

        // Roll frame
        rxq.delete();
        d0 = done_cnt;
        bus.roll_angle = 16'h1234;
        request(2'd0);
        wait_busy();
        wait_done(200, lat);
        bus.write_enable = 1'b0;
        chk("roll_latency", lat, 121);
        repeat (12) @(negedge clk);
        chk("roll_rx_count", rxq.size(), 3);
        chk_rx("roll", 0, 8'h52, 8'h34, 8'h12);
        chk("roll_done_cnt", done_cnt - d0, 1);

        // Roll then pitch with write_enable held
        rxq.delete();
        d0 = done_cnt;
        bus.pitch_angle = 16'hFF80;
        request(2'd0);
        wait_busy();
        wait_done(200, lat);
        bus.output_sel = 2'd1;
        chk("b2b_lat1", lat, 121);
        wait_busy();
        wait_done(200, lat);
        bus.write_enable = 1'b0;
        chk("b2b_lat2", lat, 121);
        repeat (20) @(negedge clk);
        chk("b2b_idle", int'(bus.busy), 0);
        chk("b2b_rx_count", rxq.size(), 6);
        chk_rx("b2b_roll", 0, 8'h52, 8'h34, 8'h12);
        chk_rx("b2b_pitch", 3, 8'h50, 8'h80, 8'hFF);
        chk("b2b_done_cnt", done_cnt - d0, 2);

        // Yaw with inputs changing mid-frame
        rxq.delete();
        d0 = done_cnt;
        bus.yaw_angle = 16'h0A0B;
        request(2'd2);
        wait_busy();
        repeat (12 * C) @(negedge clk);
        bus.yaw_angle    = 16'hFFFF;
        bus.write_enable = 1'b0;
        bus.output_sel   = 2'd0;
        wait_done(200, lat);
        chk("yaw_latency", lat, 121 - 12 * C);
        repeat (20) @(negedge clk);
        chk("yaw_rx_count", rxq.size(), 3);
        chk_rx("yaw", 0, 8'h59, 8'h0B, 8'h0A);
        chk("yaw_done_cnt", done_cnt - d0, 1);

        // Invalid select
        rxq.delete();
        d0 = done_cnt;
        request(2'd3);
        wait_busy();
        wait_done(5, lat);
        bus.write_enable = 1'b0;
        chk("inv_latency", lat, 1);
        repeat (20) @(negedge clk);
        chk("inv_rx_count", rxq.size(), 0);
        chk("inv_done_cnt", done_cnt - d0, 1);

        // Reset during byte 2
        bus.yaw_angle = 16'h0102;
        request(2'd2);
        wait_busy();
        bus.write_enable = 1'b0;
        repeat (22 * C) @(negedge clk);
        d0 = done_cnt;
        #1 n_rst = 1'b0;
        #1;
        chk("rst_mid_tx", int'(bus.tx_out), 1);
        chk("rst_mid_busy", int'(bus.busy), 0);
        repeat (15 * C) @(negedge clk);
        chk("rst_mid_done_cnt", done_cnt - d0, 0);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        rxq.delete();
        bus.pitch_angle = 16'hABCD;
        request(2'd1);
        wait_busy();
        wait_done(200, lat);
        bus.write_enable = 1'b0;
        chk("rst_after_latency", lat, 121);
        repeat (12) @(negedge clk);
        chk("rst_after_rx_count", rxq.size(), 3);
        chk_rx("rst_after", 0, 8'h50, 8'hCD, 8'hAB);

        // Randomized frames with post-LOAD input churn
        for (int n = 0; n < 10; n++) begin
            rxq.delete();
            s = 2'($urandom_range(0, 3));
            bus.roll_angle  = 16'($urandom);
            bus.pitch_angle = 16'($urandom);
            bus.yaw_angle   = 16'($urandom);
            case (s)
                2'd0:    a = bus.roll_angle;
                2'd1:    a = bus.pitch_angle;
                default: a = bus.yaw_angle;
            endcase
            request(s);
            wait_busy();
            if (s == 2'd3) begin
                wait_done(5, lat);
                chk("rand_inv_latency", lat, 1);
            end else begin
                @(negedge clk);
                bus.roll_angle  = 16'($urandom);
                bus.pitch_angle = 16'($urandom);
                bus.yaw_angle   = 16'($urandom);
                bus.output_sel  = 2'($urandom_range(0, 3));
                wait_done(200, lat);
                chk("rand_latency", lat, 120);
            end
            bus.write_enable = 1'b0;
            repeat (12) @(negedge clk);
            if (s == 2'd3) begin
                chk("rand_inv_rx_count", rxq.size(), 0);
            end else begin
                chk("rand_rx_count", rxq.size(), 3);
                chk_rx("rand", 0, tag_of(s), a[7:0], a[15:8]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
